image_stream_encoder: RTL and testbench
=======================================

Name: image_stream_encoder

Overview:
- Transmit side of the BNN image slice stream.
- Captures a full ROWS x WIDTH binary image (or feature map) in one load handshake, then serializes it one row slice per beat.
- Each beat carries a row index that drives the `sel` input of the receiving slice decoder.
- Sits between the BNN result/image buffer and the slice-wide link back toward the host-side decoder.

Parameters:
- ROWS, 8, number of row slices per image (power of two, >= 2).
- WIDTH, 8, bits per row slice.
- IDXW, $clog2(ROWS), width of the row index (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous abort; discards the buffered image and returns to IDLE.
- image_i  input  [ROWS-1:0][WIDTH-1:0]  image to send; row r = image_i[r].
- load_valid_i  input  1  image_i valid.
- load_ready_o  output  1  encoder can accept an image.
- slice_o  output  WIDTH  current row slice.
- sel_o  output  IDXW  row index of slice_o.
- slice_valid_o  output  1  slice_o/sel_o valid.
- slice_ready_i  input  1  downstream accepts beat.
- done_o  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, row counter=0, image buffer=0.
  - load_ready_o=1, slice_o=0, sel_o=0, slice_valid_o=0, done_o=0.
- States: IDLE, SEND.
- IDLE:
  - load_ready_o=1, slice_valid_o=0.
  - On load_valid_i && load_ready_o, latch image_i into the buffer, clear the counter, and go to SEND.
  - image_i is sampled only on that edge.
- SEND:
  - load_ready_o=0, slice_valid_o=1.
  - slice_o=buffer[counter], sel_o=counter. Outputs are registered/buffer-driven, not combinational from image_i.
  - First beat is presented in the cycle after the load handshake, so load-to-first-valid latency is 1 cycle.
- Beat rules:
  - A beat transfers on slice_valid_o && slice_ready_i; the counter then increments.
  - While slice_ready_i=0, slice_o, sel_o and slice_valid_o hold stable.
  - slice_valid_o never depends on slice_ready_i.
- Last beat:
  - When the beat with counter==ROWS-1 transfers, go to IDLE and assert done_o in the following cycle for exactly 1 cycle.
  - load_ready_o=1 in that same cycle.
- Throughput: with slice_ready_i held high, ROWS beats occupy ROWS consecutive cycles. Back-to-back images lose 1 idle cycle (the IDLE load cycle).
- Counter: modulo-ROWS, wraps to 0 on the final beat. Never exceeds ROWS-1.
- Flush:
  - flush_i=1 forces IDLE, counter=0, slice_valid_o=0, done_o=0 on the next edge.
  - A load attempted in the same cycle is dropped.
  - flush_i has priority over every handshake.
- Reset mid-transfer: outputs return immediately to reset values; the partial image is not resumed.
- done_o and load handshakes are mutually exclusive in a cycle only through state. A load arriving in the done_o cycle is accepted normally.

Optional Feature:
- Macro: IMAGE_STREAM_CHKSUM_EN.
- Defined:
  - After row ROWS-1 transfers, the FSM enters state CHK and emits one extra beat.
  - That beat carries slice_o = XOR of all ROWS buffered rows and sel_o = 0, with slice_valid_o=1 and the same hold rules.
  - done_o pulses after the CHK beat transfers. A transfer is ROWS+1 beats.
  - Flush and reset in CHK behave as in SEND.
- Undefined: no CHK state, no extra beat, and behaviour is exactly as above.

Decomposition:
- Shared package image_stream_pkg:
  - ROWS_DEF=8 and WIDTH_DEF=8, used by both encoder and decoder.
  - enc_state_t enum {IDLE, SEND, CHK}; CHK is present only under the macro.
  - function row_xor(image) for the checksum, reusable by the receive-side checker.
- One sub-module, image_row_buffer: ROWS x WIDTH register array with load enable, asynchronous active-low clear, and a row-read mux addressed by the counter.
- FSM and counter stay in the top module.

Test Plan:
- Single image, ready always high:
  - Load rows 0x01,0x02,...,0x08.
  - Expect slice_valid_o high for 8 consecutive cycles starting 1 cycle after the load, with (sel_o,slice_o)=(0,0x01)...(7,0x08).
  - Expect done_o on the cycle after the last beat.
- Backpressure:
  - Same image, slice_ready_i low for 3 cycles during row 4.
  - Expect (4,0x05) held stable for all stalled cycles and no duplicated or skipped rows.
- Back-to-back:
  - Assert load_valid_i with image B (0xA5 all rows) in the done_o cycle of image A.
  - Expect B accepted in that cycle and B's first beat in the next cycle.
- Flush mid-stream:
  - Assert flush_i during the row-2 beat.
  - Expect slice_valid_o=0 and load_ready_o=1 in the next cycle, no done_o, and a subsequent image starting again at sel_o=0.
- Async reset:
  - Drop rst_n mid-cycle during row 5.
  - Expect all outputs at reset values immediately, before the next clk edge.
- IMAGE_STREAM_CHKSUM_EN:
  - Rows 0x01..0x08.
  - Expect a 9th beat (0,0x08), since the XOR of 0x01..0x08 is 0x08, then done_o.
  - Without the macro, expect done_o after 8 beats.

Source files
------------

// File: rtl/image_stream_pkg.sv
// Shared definitions for the BNN image slice stream (encoder and decoder sides).
// IMAGE_STREAM_CHKSUM_EN adds the CHK state used for the trailing checksum beat.
package image_stream_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef IMAGE_STREAM_CHKSUM_EN
    , CHK = 2'd2
`endif
  } enc_state_t;

  // Checksum of a default-sized image; the receive-side checker uses the same fold.
  function automatic logic [WIDTH_DEF-1:0] row_xor(
    input logic [ROWS_DEF-1:0][WIDTH_DEF-1:0] image
  );
    logic [WIDTH_DEF-1:0] acc;
    acc = '0;
    for (int r = 0; r < ROWS_DEF; r++) acc ^= image[r];
    return acc;
  endfunction

endpackage

// File: rtl/image_stream_encoder_if.sv
// Load and slice-stream handshake bundle of the image stream encoder.
// master = encoder side, slave = image source / slice sink side.
interface image_stream_encoder_if
  import image_stream_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int IDXW = $clog2(ROWS);

  logic [ROWS-1:0][WIDTH-1:0] image_i;
  logic                       load_valid_i;
  logic                       load_ready_o;
  logic [WIDTH-1:0]           slice_o;
  logic [IDXW-1:0]            sel_o;
  logic                       slice_valid_o;
  logic                       slice_ready_i;
  logic                       done_o;

  modport master (
    input  image_i, load_valid_i, slice_ready_i,
    output load_ready_o, slice_o, sel_o, slice_valid_o, done_o
  );

  modport slave (
    output image_i, load_valid_i, slice_ready_i,
    input  load_ready_o, slice_o, sel_o, slice_valid_o, done_o
  );

endinterface

// File: rtl/image_row_buffer.sv
// ROWS x WIDTH image store: whole-image load, async clear, row read mux.
module image_row_buffer
  import image_stream_pkg::*;
#(
  parameter  int ROWS  = ROWS_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDXW  = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic [ROWS-1:0][WIDTH-1:0] image_i,
  input  logic [IDXW-1:0]            addr_i,
  output logic [WIDTH-1:0]           row_o
);

  logic [ROWS-1:0][WIDTH-1:0] rows_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rows_q <= '0;
    else if (load_i) rows_q <= image_i;
  end

  assign row_o = rows_q[addr_i];

endmodule

// File: rtl/image_stream_encoder.sv
// Captures one binary image and streams it out one row slice per beat with its row index.
// Define IMAGE_STREAM_CHKSUM_EN to append an XOR-of-rows checksum beat (sel=0).
//
// state | meaning
// IDLE  | buffer free, load_ready_o high, no beat presented
// SEND  | presenting row cnt_q of the buffered image
// CHK   | presenting checksum beat (IMAGE_STREAM_CHKSUM_EN only)
module image_stream_encoder
  import image_stream_pkg::*;
#(
  parameter  int ROWS  = ROWS_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDXW  = $clog2(ROWS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  image_stream_encoder_if.master        bus
);

  enc_state_t       state_q, state_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load_en;
  logic [WIDTH-1:0] row;

  image_row_buffer #(.ROWS(ROWS), .WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_en),
    .image_i (bus.image_i),
    .addr_i  (cnt_q),
    .row_o   (row)
  );

`ifdef IMAGE_STREAM_CHKSUM_EN
  logic [WIDTH-1:0] chk_q, chk_in;

  // Folded at load time so the CHK beat needs no extra pass over the buffer.
  always_comb begin
    chk_in = '0;
    for (int r = 0; r < ROWS; r++) chk_in ^= bus.image_i[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       chk_q <= '0;
    else if (load_en) chk_q <= chk_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load_en = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_valid_i) begin
            load_en = 1'b1;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (bus.slice_ready_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDXW'(ROWS - 1)) begin
`ifdef IMAGE_STREAM_CHKSUM_EN
              state_d = CHK;
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end
          end
        end
`ifdef IMAGE_STREAM_CHKSUM_EN
        CHK: begin
          if (bus.slice_ready_i) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.load_ready_o  = (state_q == IDLE);
  assign bus.slice_valid_o = (state_q != IDLE);
  assign bus.sel_o         = cnt_q;
  assign bus.done_o        = done_q;

`ifdef IMAGE_STREAM_CHKSUM_EN
  assign bus.slice_o = (state_q == SEND) ? row :
                       (state_q == CHK)  ? chk_q : '0;
`else
  assign bus.slice_o = (state_q == SEND) ? row : '0;
`endif

endmodule

// File: tb/tb_image_stream_encoder.sv
// Self-checking bench for image_stream_encoder: table of images with stall patterns,
// beat scoreboard, plus flush and async-reset sequences.
module tb_image_stream_encoder;
  import image_stream_pkg::*;

  localparam int ROWS  = 8;
  localparam int WIDTH = 8;
`ifdef IMAGE_STREAM_CHKSUM_EN
  localparam int NCHK = 1;
`else
  localparam int NCHK = 0;
`endif

  typedef struct {
    logic [ROWS-1:0][WIDTH-1:0] img;
    int                         stall_row;
    int                         stall_len;
    int                         exp_cycles;
  } vec_t;

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] slice;
    bit               last;
  } beat_t;

  logic clk, rst_n, flush_i;
  image_stream_encoder_if #(.ROWS(ROWS), .WIDTH(WIDTH)) bus ();

  image_stream_encoder #(.ROWS(ROWS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t sb[$];
  bit    done_exp_next = 0;
  bit    prev_valid = 0, prev_ready = 0;
  logic [2:0]       prev_sel;
  logic [WIDTH-1:0] prev_slice;
  vec_t  tbl[5];
  logic [ROWS-1:0][WIDTH-1:0] img_inc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat monitor: sampled on the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      chk("done", bus.done_o, done_exp_next);
      done_exp_next = 0;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", bus.slice_valid_o, 1);
        chk("hold_sel", bus.sel_o, prev_sel);
        chk("hold_slice", bus.slice_o, prev_slice);
      end
      if (bus.slice_valid_o && bus.slice_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_sel", bus.sel_o, e.sel);
          chk("beat_slice", bus.slice_o, e.slice);
          done_exp_next = e.last;
        end
      end
      prev_valid = bus.slice_valid_o;
      prev_ready = bus.slice_ready_i;
      prev_sel   = bus.sel_o;
      prev_slice = bus.slice_o;
    end
  end

  task automatic start_load(input logic [ROWS-1:0][WIDTH-1:0] img);
    beat_t b;
    chk("load_ready_idle", bus.load_ready_o, 1);
    for (int r = 0; r < ROWS; r++) begin
      b.sel = 3'(r);
      b.slice = img[r];
      b.last = (r == ROWS - 1) && (NCHK == 0);
      sb.push_back(b);
    end
`ifdef IMAGE_STREAM_CHKSUM_EN
    b.sel = 3'd0;
    b.slice = row_xor(img);
    b.last = 1'b1;
    sb.push_back(b);
`endif
    bus.image_i = img;
    bus.load_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.load_valid_i = 1'b0;
    bus.image_i = ~img;
    chk("first_valid", bus.slice_valid_o, 1);
    chk("first_sel", bus.sel_o, 0);
    chk("load_ready_busy", bus.load_ready_o, 0);
  endtask

  // Streams one image and returns in its done_o cycle (#1 after the edge).
  task automatic send_image(input vec_t v);
    int cyc = 0;
    int stalled = 0;
    bit stall_now;
    start_load(v.img);
    stall_now = bus.slice_valid_o && (int'(bus.sel_o) == v.stall_row) && (stalled < v.stall_len);
    if (stall_now) stalled++;
    bus.slice_ready_i = !stall_now;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done_o) break;
      stall_now = bus.slice_valid_o && (int'(bus.sel_o) == v.stall_row) && (stalled < v.stall_len);
      if (stall_now) stalled++;
      bus.slice_ready_i = !stall_now;
    end
    bus.slice_ready_i = 1'b1;
    chk("xfer_cycles", cyc, v.exp_cycles);
    chk("done_cycle_load_ready", bus.load_ready_o, 1);
  endtask

  task automatic wait_sel(input int row);
    int n = 0;
    while (int'(bus.sel_o) != row && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_sel_timeout", (n < 50), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    bus.load_valid_i = 1'b0;
    bus.slice_ready_i = 1'b1;
    bus.image_i = '0;
    #2;
    chk("rst_load_ready", bus.load_ready_o, 1);
    chk("rst_slice", bus.slice_o, 0);
    chk("rst_sel", bus.sel_o, 0);
    chk("rst_valid", bus.slice_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < ROWS; r++) img_inc[r] = 8'(r + 1);
    tbl[0].img = img_inc;               tbl[0].stall_row = -1; tbl[0].stall_len = 0;
    tbl[1].img = img_inc;               tbl[1].stall_row = 4;  tbl[1].stall_len = 3;
    tbl[2].img = {ROWS{8'hA5}};         tbl[2].stall_row = -1; tbl[2].stall_len = 0;
    tbl[3].img = 64'h80_3C_FF_00_5A_C3_7E_01; tbl[3].stall_row = 0; tbl[3].stall_len = 1;
    tbl[4].img = 64'h12_34_56_78_9A_BC_DE_F0; tbl[4].stall_row = 7; tbl[4].stall_len = 2;
    for (int i = 0; i < 5; i++) tbl[i].exp_cycles = ROWS + NCHK + tbl[i].stall_len;

    // Consecutive entries load in the previous image's done_o cycle.
    for (int i = 0; i < 5; i++) send_image(tbl[i]);

    // Flush during the row-2 beat, with a load offered in the same cycle.
    start_load(img_inc);
    wait_sel(2);
    flush_i = 1'b1;
    bus.load_valid_i = 1'b1;
    bus.image_i = {ROWS{8'h3C}};
    @(posedge clk); #1;
    flush_i = 1'b0;
    bus.load_valid_i = 1'b0;
    sb.delete();
    done_exp_next = 0;
    chk("flush_valid", bus.slice_valid_o, 0);
    chk("flush_load_ready", bus.load_ready_o, 1);
    chk("flush_done", bus.done_o, 0);
    chk("flush_sel", bus.sel_o, 0);
    @(posedge clk); #1;
    chk("flush_load_dropped", bus.slice_valid_o, 0);
    send_image(tbl[0]);

    // Async reset in the middle of row 5, checked before the next edge.
    start_load(img_inc);
    wait_sel(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load_ready", bus.load_ready_o, 1);
    chk("arst_slice", bus.slice_o, 0);
    chk("arst_sel", bus.sel_o, 0);
    chk("arst_valid", bus.slice_valid_o, 0);
    chk("arst_done", bus.done_o, 0);
    sb.delete();
    done_exp_next = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_image(tbl[2]);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
